// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loadable pattern, selectable overlap
// mode and a saturating detection counter. Match flag is Mealy (zero latency).
module seq_detector_param #(
    parameter int              N       = 4,
    parameter logic [N-1:0]    PATTERN = 4'b1011,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data,
    input  logic             overlap,
    input  logic             load,
    input  logic [N-1:0]     pattern_in,
    output logic             detected,
    output logic [CNT_W-1:0] count
);

    localparam int FILL_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N - 1);

    logic [N-1:0]     r_pat;
    logic [N-2:0]     r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [CNT_W-1:0] r_count;

    logic [N-1:0]     w_window;
    logic             w_match;

    assign w_window = {r_hist, data};
    // Only a fully populated history may match, so bits from before reset/load never count.
    assign w_match  = ~rst & ~load & en & (r_fill == FILL_FULL) & (w_window == r_pat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat   <= PATTERN;
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
        end else if (load) begin
            r_pat   <= pattern_in;
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
        end else if (en) begin
            r_hist <= w_window[N-2:0];
            if (w_match) begin
                r_fill <= overlap ? FILL_FULL : '0;
                if (~&r_count)
                    r_count <= r_count + 1'b1;
            end else if (r_fill != FILL_FULL) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign detected = w_match;
    assign count    = r_count;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: vector table through a scoreboard
// queue, plus hand sequences for async reset and counter saturation.
module tb_seq_detector_param;

    typedef struct {
        logic        en;
        logic        data;
        logic        ovl;
        logic        load;
        logic [3:0]  pin;
        logic        exp_det;
        logic [7:0]  exp_cnt;
        string       name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, en, data, overlap, load;
    logic [3:0] pattern_in;
    logic       detected, sat_det;
    logic [7:0] count;
    logic [1:0] sat_cnt;

    int checks   = 0;
    int failures = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .data(data), .overlap(overlap),
        .load(load), .pattern_in(pattern_in), .detected(detected), .count(count)
    );

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .data(data), .overlap(overlap),
        .load(load), .pattern_in(pattern_in), .detected(sat_det), .count(sat_cnt)
    );

    function automatic vec_t mk(input logic e, input logic d, input logic o, input logic l,
                                input logic [3:0] p, input logic xd, input logic [7:0] xc,
                                input string nm);
        vec_t v;
        v.en = e; v.data = d; v.ovl = o; v.load = l; v.pin = p;
        v.exp_det = xd; v.exp_cnt = xc; v.name = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1; detected sampled at negedge, count just after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        en = v.en; data = v.data; overlap = v.ovl; load = v.load; pattern_in = v.pin;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({e.name, " det"}, {31'd0, detected}, {31'd0, e.exp_det});
        @(posedge clk);
        #1;
        chk({e.name, " cnt"}, {24'd0, count}, {24'd0, e.exp_cnt});
    endtask

    initial begin
        int k;
        logic xd;
        rst = 1'b1; en = 1'b0; data = 1'b0; overlap = 1'b0; load = 1'b0; pattern_in = 4'd0;
        #2;
        chk("reset det", {31'd0, detected}, 32'd0);
        chk("reset cnt", {24'd0, count}, 32'd0);
        chk("reset sat_cnt", {30'd0, sat_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // overlap mode, stream 1,0,1,1,0,1,1
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, "ovl b1"));
        tbl.push_back(mk(1, 0, 1, 0, 4'h0, 0, 0, "ovl b2"));
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, "ovl b3"));
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 1, 1, "ovl b4"));
        tbl.push_back(mk(1, 0, 1, 0, 4'h0, 0, 1, "ovl b5"));
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 1, "ovl b6"));
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 1, 2, "ovl b7"));
        // reload same pattern clears count; non-overlap stream
        tbl.push_back(mk(1, 1, 0, 1, 4'hB, 0, 0, "load1011"));
        tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 0, "novl b1"));
        tbl.push_back(mk(1, 0, 0, 0, 4'h0, 0, 0, "novl b2"));
        tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 0, "novl b3"));
        tbl.push_back(mk(1, 1, 0, 0, 4'h0, 1, 1, "novl b4"));
        tbl.push_back(mk(1, 0, 0, 0, 4'h0, 0, 1, "novl b5"));
        tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 1, "novl b6"));
        tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 1, "novl b7"));
        // enable gating
        tbl.push_back(mk(1, 1, 0, 1, 4'hB, 0, 0, "load gate"));
        tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 0, "gate b1"));
        tbl.push_back(mk(1, 0, 0, 0, 4'h0, 0, 0, "gate b2"));
        tbl.push_back(mk(0, 1, 0, 0, 4'h0, 0, 0, "gate off1"));
        tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, "gate off2"));
        tbl.push_back(mk(0, 1, 0, 0, 4'h0, 0, 0, "gate off3"));
        tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 0, "gate b3"));
        tbl.push_back(mk(1, 1, 0, 0, 4'h0, 1, 1, "gate b4"));
        // runtime load of 1101, overlap stream 1,1,0,1,1,0,1
        tbl.push_back(mk(1, 1, 1, 1, 4'hD, 0, 0, "load1101"));
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, "rl b1"));
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, "rl b2"));
        tbl.push_back(mk(1, 0, 1, 0, 4'h0, 0, 0, "rl b3"));
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 1, 1, "rl b4"));
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 1, "rl b5 old1011"));
        tbl.push_back(mk(1, 0, 1, 0, 4'h0, 0, 1, "rl b6"));
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 1, 2, "rl b7"));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i]);

        // Async reset between edges: window {101,1}=1011 would match the reset
        // pattern if fill were not cleared, so detected must stay 0.
        #1;
        rst = 1'b1; en = 1'b1; data = 1'b1; load = 1'b0; overlap = 1'b1;
        #1;
        chk("async det", {31'd0, detected}, 32'd0);
        chk("async cnt", {24'd0, count}, 32'd0);
        #1;
        rst = 1'b0; en = 1'b0;
        @(posedge clk);
        #1;
        step(mk(1, 1, 1, 0, 4'h0, 0, 0, "post-rst single1"));
        step(mk(1, 0, 1, 0, 4'h0, 0, 0, "post-rst b2"));
        step(mk(1, 1, 1, 0, 4'h0, 0, 0, "post-rst b3"));
        step(mk(1, 1, 1, 0, 4'h0, 1, 1, "post-rst b4"));

        // Saturation on CNT_W=2 instance: 1011 then repeated 011, overlap on.
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0; en = 1'b1; overlap = 1'b1; load = 1'b0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            data = (i % 3 == 1) ? 1'b0 : 1'b1;
            xd = (i >= 3) && ((i % 3) == 0);
            @(negedge clk);
            chk($sformatf("sat det %0d", i), {31'd0, sat_det}, {31'd0, xd});
            if (xd) k++;
            @(posedge clk);
            #1;
            chk($sformatf("sat cnt %0d", i), {30'd0, sat_cnt}, (k > 3) ? 32'd3 : k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
